// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcodes,
// datapath mux codes and the packed control word driven onto the datapath.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_AEX    = 4'd10,
        S_AWB    = 4'd11,
        S_JMP    = 4'd12
    } state_t;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_J    = 6'b000010;

    // ALUOp codes are also consumed by AluControl.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure state-to-control-word lookup; FETCH's PC/IR loads are later gated
// by mem_ready in the FSM top.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0]        i_state,
    output logic [CTRL_W-1:0] o_ctrl
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                w_ctrl.memRead = 1'b1;
                w_ctrl.irWrite = 1'b1;
                w_ctrl.pcWrite = 1'b1;
                w_ctrl.aluSrcB = SRCB_FOUR;
            end
            S_DECODE: begin
                w_ctrl.aluSrcB = SRCB_SEXT_SH2;
            end
            S_MEMADR: begin
                w_ctrl.aluSrcA = 1'b1;
                w_ctrl.aluSrcB = SRCB_SEXT;
            end
            S_MEMRD: begin
                w_ctrl.memRead = 1'b1;
                w_ctrl.iorD    = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.regWrite = 1'b1;
                w_ctrl.memToReg = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.memWrite = 1'b1;
                w_ctrl.iorD     = 1'b1;
            end
            S_REX: begin
                w_ctrl.aluSrcA = 1'b1;
                w_ctrl.aluOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                w_ctrl.regWrite = 1'b1;
                w_ctrl.regDst   = 1'b1;
            end
            S_BEQ: begin
                w_ctrl.aluSrcA     = 1'b1;
                w_ctrl.aluOp       = ALUOP_SUB;
                w_ctrl.pcWriteCond = 1'b1;
                w_ctrl.pcSource    = PCSRC_ALUOUT;
            end
            S_AEX: begin
                w_ctrl.aluSrcA = 1'b1;
                w_ctrl.aluSrcB = SRCB_SEXT;
            end
            S_AWB: begin
                w_ctrl.regWrite = 1'b1;
            end
            S_JMP: begin
                w_ctrl.pcWrite  = 1'b1;
                w_ctrl.pcSource = PCSRC_JUMP;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: state register, next-state sequencing,
// memory wait-state stalls, sticky illegal-opcode flag and retire counter.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] OP_R    = OPC_R,
    parameter logic [5:0] OP_LW   = OPC_LW,
    parameter logic [5:0] OP_SW   = OPC_SW,
    parameter logic [5:0] OP_BEQ  = OPC_BEQ,
    parameter logic [5:0] OP_ADDI = OPC_ADDI,
    parameter logic [5:0] OP_J    = OPC_J
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       Op,
    input  logic             zf,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemToWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             bad_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    state_t             r_state;
    state_t             w_next;
    logic               r_badOp;
    logic [CNT_W-1:0]   r_retired;
    logic               w_retire;
    logic               w_illegal;
    logic               w_fetchGate;
    logic [CTRL_W-1:0]  w_ctrlBits;
    ctrl_t              w_ctrl;
    logic               w_unusedZf;

    // zf is consumed by the datapath (ANDed with PCWriteCond), not here.
    assign w_unusedZf = zf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_retire  = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_REX;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_ADDI:      w_next = S_AEX;
                    OP_J:         w_next = S_JMP;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = run ? S_FETCH : S_IDLE;
                    end
                endcase
            end
            S_MEMADR: w_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_retire = 1'b1;
            S_REX:    w_next = S_RWB;
            S_AEX:    w_next = S_AWB;
            S_MEMWB, S_RWB, S_BEQ, S_AWB, S_JMP: w_retire = 1'b1;
            default:  w_next = S_IDLE;
        endcase
        if (w_retire) begin
            w_next = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_badOp   <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_illegal) r_badOp <= 1'b1;
            if (w_retire)  r_retired <= r_retired + CNT_W'(1);
        end
    end

    mc_ctrl_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrlBits)
    );

    assign w_ctrl      = ctrl_t'(w_ctrlBits);
    // PC and IR only load on the cycle the instruction fetch completes.
    assign w_fetchGate = (r_state == S_FETCH) ? mem_ready : 1'b1;

    assign PCWrite     = w_ctrl.pcWrite & w_fetchGate;
    assign IRWrite     = w_ctrl.irWrite & w_fetchGate;
    assign PCWriteCond = w_ctrl.pcWriteCond;
    assign IorD        = w_ctrl.iorD;
    assign MemRead     = w_ctrl.memRead;
    assign MemToWrite  = w_ctrl.memWrite;
    assign RegDst      = w_ctrl.regDst;
    assign MemToReg    = w_ctrl.memToReg;
    assign RegWrite    = w_ctrl.regWrite;
    assign ALUSrcA     = w_ctrl.aluSrcA;
    assign ALUSrcB     = w_ctrl.aluSrcB;
    assign ALUOp       = w_ctrl.aluOp;
    assign PCSource    = w_ctrl.pcSource;

    assign bad_op      = r_badOp;
    assign retired     = r_retired;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each driven cycle pushes the expected
// state, control word, counter and flag, which are popped and compared.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [5:0]  Op;
    logic        zf;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite;
    logic        RegDst, MemToReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic        bad_op;
    logic [31:0] retired;
    logic [3:0]  state_dbg;

    typedef struct packed {
        logic [3:0]  st;
        logic [31:0] ret;
        logic        bad;
        logic [15:0] ctrl;
    } exp_t;

    exp_t        sbQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] expRetired = 0;
    logic        expBadOp   = 1'b0;
    logic [15:0] actCtrl;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .Op(Op), .zf(zf), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemToWrite(MemToWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .bad_op(bad_op), .retired(retired), .state_dbg(state_dbg)
    );

    assign actCtrl = {PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite,
                      RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    // Expected control word per state, bit order matching actCtrl.
    function automatic logic [15:0] expCtrl(input state_t st, input logic mr);
        logic pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, sa;
        logic [1:0] sb, aop, psrc;
        {pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, sa} = '0;
        sb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            S_FETCH:  begin mrd = 1; pw = mr; irw = mr; sb = 2'b01; end
            S_DECODE: sb = 2'b11;
            S_MEMADR: begin sa = 1; sb = 2'b10; end
            S_MEMRD:  begin mrd = 1; iod = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mwr = 1; iod = 1; end
            S_REX:    begin sa = 1; aop = 2'b10; end
            S_RWB:    begin rw = 1; rdst = 1; end
            S_BEQ:    begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            S_AEX:    begin sa = 1; sb = 2'b10; end
            S_AWB:    rw = 1;
            S_JMP:    begin pw = 1; psrc = 2'b10; end
            default:  ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, psrc};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, compare just after.
    task automatic applyStimulus(input logic r, input logic [5:0] op, input logic mr,
                                 input logic z, input state_t st);
        exp_t e;
        @(negedge clk);
        run = r; Op = op; mem_ready = mr; zf = z;
        sbQ.push_back({st, expRetired, expBadOp, expCtrl(st, mr)});
        #1;
        e = sbQ.pop_front();
        checkOutput($sformatf("state_%0d", e.st), 64'(state_dbg), 64'(e.st));
        checkOutput($sformatf("ctrl_%0d", e.st), 64'(actCtrl), 64'(e.ctrl));
        checkOutput($sformatf("retired_%0d", e.st), 64'(retired), 64'(e.ret));
        checkOutput($sformatf("bad_op_%0d", e.st), 64'(bad_op), 64'(e.bad));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b1; Op = OPC_LW; mem_ready = 1'b1; zf = 1'b0;
        repeat (2) @(posedge clk);
        applyStimulus(1, OPC_LW, 1, 0, S_IDLE);
        rst = 1'b0;

        $display("[TB] LW with no wait states");
        applyStimulus(1, OPC_LW, 1, 0, S_FETCH);
        applyStimulus(1, OPC_LW, 1, 0, S_DECODE);
        applyStimulus(1, OPC_LW, 1, 0, S_MEMADR);
        applyStimulus(1, OPC_LW, 1, 0, S_MEMRD);
        applyStimulus(1, OPC_LW, 1, 0, S_MEMWB);
        expRetired++;

        $display("[TB] SW with three wait states");
        applyStimulus(1, OPC_SW, 1, 0, S_FETCH);
        applyStimulus(1, OPC_SW, 1, 0, S_DECODE);
        applyStimulus(1, OPC_SW, 1, 0, S_MEMADR);
        for (int i = 0; i < 3; i++) applyStimulus(1, OPC_SW, 0, 0, S_MEMWR);
        applyStimulus(1, OPC_SW, 1, 0, S_MEMWR);
        expRetired++;

        $display("[TB] BEQ with zf=0 and zf=1");
        for (int z = 0; z < 2; z++) begin
            applyStimulus(1, OPC_BEQ, 1, z[0], S_FETCH);
            applyStimulus(1, OPC_BEQ, 1, z[0], S_DECODE);
            applyStimulus(1, OPC_BEQ, 1, z[0], S_BEQ);
            expRetired++;
        end

        $display("[TB] ADDI with fetch wait states");
        applyStimulus(1, OPC_ADDI, 0, 0, S_FETCH);
        applyStimulus(1, OPC_ADDI, 0, 0, S_FETCH);
        applyStimulus(1, OPC_ADDI, 1, 0, S_FETCH);
        applyStimulus(1, OPC_ADDI, 1, 0, S_DECODE);
        applyStimulus(1, OPC_ADDI, 1, 0, S_AEX);
        applyStimulus(1, OPC_ADDI, 1, 0, S_AWB);
        expRetired++;

        $display("[TB] J");
        applyStimulus(1, OPC_J, 1, 0, S_FETCH);
        applyStimulus(1, OPC_J, 1, 0, S_DECODE);
        applyStimulus(1, OPC_J, 1, 0, S_JMP);
        expRetired++;

        $display("[TB] illegal opcode");
        applyStimulus(1, 6'b111111, 1, 0, S_FETCH);
        applyStimulus(1, 6'b111111, 1, 0, S_DECODE);
        expBadOp = 1'b1;

        $display("[TB] R-type with run dropped mid-instruction");
        applyStimulus(1, OPC_R, 1, 0, S_FETCH);
        applyStimulus(1, OPC_R, 1, 0, S_DECODE);
        applyStimulus(0, OPC_R, 1, 0, S_REX);
        applyStimulus(0, OPC_R, 1, 0, S_RWB);
        expRetired++;
        applyStimulus(0, OPC_R, 1, 0, S_IDLE);
        applyStimulus(1, OPC_LW, 1, 0, S_IDLE);
        applyStimulus(1, OPC_LW, 1, 0, S_FETCH);

        $display("[TB] async reset mid-MEMRD");
        applyStimulus(1, OPC_LW, 1, 0, S_DECODE);
        applyStimulus(1, OPC_LW, 1, 0, S_MEMADR);
        applyStimulus(1, OPC_LW, 0, 0, S_MEMRD);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_state", 64'(state_dbg), 64'd0);
        checkOutput("rst_regwrite", 64'(RegWrite), 64'd0);
        checkOutput("rst_retired", 64'(retired), 64'd0);
        checkOutput("rst_bad_op", 64'(bad_op), 64'd0);
        expRetired = 0;
        expBadOp   = 1'b0;
        applyStimulus(1, OPC_LW, 1, 0, S_IDLE);
        rst = 1'b0;
        applyStimulus(1, OPC_LW, 1, 0, S_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
